// File: rtl/ad_ip_jesd204_tpl_dac_datapath.sv
// rtl/ad_ip_jesd204_tpl_dac_datapath.sv - JESD204 TPL DAC sample source mux, ramp/PRBS generators and link beat register
// Optional PRBS7 sources compiled in with macro TPL_DAC_PRBS_EN.
module ad_ip_jesd204_tpl_dac_datapath #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_CHANNELS    = 2,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int EXT_SYNC        = 0,
  localparam int LDW = NUM_LANES * 8 * OCTETS_PER_BEAT,
  localparam int DPW = LDW / (NUM_CHANNELS * BITS_PER_SAMPLE)
) (
  input  logic                                    link_clk,
  input  logic                                    link_resetn,
  input  logic                                    link_ready,
  output logic                                    link_valid,
  output logic [LDW-1:0]                          link_data,
  input  logic [NUM_CHANNELS-1:0]                 enable,
  output logic [NUM_CHANNELS-1:0]                 dac_valid,
  input  logic [LDW-1:0]                          dac_ddata,
  input  logic                                    dac_dunf,
  input  logic [NUM_CHANNELS*4-1:0]               dac_data_sel,
  input  logic [NUM_CHANNELS*BITS_PER_SAMPLE-1:0] dac_pat_data,
  input  logic                                    dac_sync,
  input  logic                                    ext_sync,
  output logic [1:0]                              sync_state,
  input  logic                                    dunf_clr,
  output logic                                    dunf_sticky
);

  localparam int BPS = BITS_PER_SAMPLE;
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ARMED = 2'd1;
  localparam logic [1:0] STATE_RUN   = 2'd2;
  localparam logic [1:0] STATE_RESET = (EXT_SYNC != 0) ? STATE_IDLE : STATE_RUN;
  localparam logic [BPS-1:0] RAMP_INC = BPS'(DPW);

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic           run;
  logic           enter_run;
  logic           load;
  logic           dma_any;
  logic [BPS-1:0] ramp_base;
  logic [LDW-1:0] src_data;

  assign run        = (state == STATE_RUN);
  assign enter_run  = (state_next == STATE_RUN) && !run;
  assign sync_state = state;
  // Source is consumed whenever the beat register can take a new word.
  assign load       = link_ready | ~link_valid;

  always_comb begin
    state_next = state;
    if (EXT_SYNC == 0) begin
      state_next = STATE_RUN;
    end else begin
      case (state)
        STATE_IDLE:  if (dac_sync) state_next = STATE_ARMED;
        STATE_ARMED: if (ext_sync) state_next = STATE_RUN;
        STATE_RUN:   if (dac_sync) state_next = STATE_ARMED;
        default:     state_next = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge link_clk) begin
    if (!link_resetn) begin
      state <= STATE_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    dac_valid = '0;
    dma_any   = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (enable[c] && dac_data_sel[4*c +: 4] == 4'd0) begin
        dma_any      = 1'b1;
        dac_valid[c] = link_resetn & link_ready & run;
      end
    end
  end

`ifdef TPL_DAC_PRBS_EN
  logic [6:0]         prbs_state [NUM_CHANNELS];
  logic [6:0]         prbs_next  [NUM_CHANNELS];
  logic [DPW*BPS-1:0] prbs_data  [NUM_CHANNELS];

  // Serial PRBS7 unrolled over one beat; first generated bit lands in the MSB of sample 0.
  always_comb begin : prbs_gen
    logic [6:0] s;
    logic       fb;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      s            = prbs_state[c];
      prbs_data[c] = '0;
      for (int j = 0; j < DPW; j++) begin
        for (int b = 0; b < BPS; b++) begin
          fb = s[6] ^ s[5];
          s  = {s[5:0], fb};
          prbs_data[c][j*BPS + (BPS-1-b)] = fb;
        end
      end
      prbs_next[c] = s;
    end
  end

  always_ff @(posedge link_clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!link_resetn) begin
        prbs_state[c] <= 7'h7f;
      end else if (load) begin
        prbs_state[c] <= prbs_next[c];
      end
    end
  end
`endif

  always_comb begin
    src_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int j = 0; j < DPW; j++) begin
        if (enable[c] && run) begin
          case (dac_data_sel[4*c +: 4])
            4'd0: src_data[(c*DPW+j)*BPS +: BPS] = dac_ddata[(c*DPW+j)*BPS +: BPS];
            4'd1: src_data[(c*DPW+j)*BPS +: BPS] = dac_pat_data[c*BPS +: BPS];
            4'd2: src_data[(c*DPW+j)*BPS +: BPS] = ramp_base + BPS'(j);
`ifdef TPL_DAC_PRBS_EN
            4'd3: src_data[(c*DPW+j)*BPS +: BPS] = prbs_data[c][j*BPS +: BPS];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Ramp restarts on every entry into RUN so each sync gives a known phase.
  always_ff @(posedge link_clk) begin
    if (!link_resetn) begin
      ramp_base <= '0;
    end else if (enter_run) begin
      ramp_base <= '0;
    end else if (load) begin
      ramp_base <= ramp_base + RAMP_INC;
    end
  end

  always_ff @(posedge link_clk) begin
    if (!link_resetn) begin
      link_valid <= 1'b0;
      link_data  <= '0;
    end else begin
      link_valid <= 1'b1;
      if (load) begin
        link_data <= src_data;
      end
    end
  end

  always_ff @(posedge link_clk) begin
    if (!link_resetn) begin
      dunf_sticky <= 1'b0;
    end else if (dac_dunf && run && dma_any) begin
      dunf_sticky <= 1'b1;
    end else if (dunf_clr) begin
      dunf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_datapath.sv
// tb/tb_ad_ip_jesd204_tpl_dac_datapath.sv - directed bench for the TPL DAC datapath
// dut0: free-running (EXT_SYNC=0), dut1: sync-gated, dut2: two lanes (DPW=2) for ramp wrap.
module tb_ad_ip_jesd204_tpl_dac_datapath;

  logic         clk = 1'b0;
  logic         link_resetn;
  logic         link_ready;
  logic [1:0]   enable;
  logic [127:0] dac_ddata;
  logic         dac_dunf;
  logic [7:0]   dac_data_sel;
  logic [31:0]  dac_pat_data;
  logic         dac_sync;
  logic         ext_sync;
  logic         dunf_clr;

  logic         link_valid0, link_valid1, link_valid2;
  logic [127:0] link_data0, link_data1;
  logic [63:0]  link_data2;
  logic [1:0]   dac_valid0, dac_valid1, dac_valid2;
  logic [1:0]   sync_state0, sync_state1, sync_state2;
  logic         dunf_sticky0, dunf_sticky1, dunf_sticky2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_datapath #(.EXT_SYNC(0)) dut0 (
    .link_clk(clk), .link_resetn(link_resetn), .link_ready(link_ready),
    .link_valid(link_valid0), .link_data(link_data0), .enable(enable),
    .dac_valid(dac_valid0), .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
    .dac_data_sel(dac_data_sel), .dac_pat_data(dac_pat_data), .dac_sync(dac_sync),
    .ext_sync(ext_sync), .sync_state(sync_state0), .dunf_clr(dunf_clr),
    .dunf_sticky(dunf_sticky0));

  ad_ip_jesd204_tpl_dac_datapath #(.EXT_SYNC(1)) dut1 (
    .link_clk(clk), .link_resetn(link_resetn), .link_ready(link_ready),
    .link_valid(link_valid1), .link_data(link_data1), .enable(enable),
    .dac_valid(dac_valid1), .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
    .dac_data_sel(dac_data_sel), .dac_pat_data(dac_pat_data), .dac_sync(dac_sync),
    .ext_sync(ext_sync), .sync_state(sync_state1), .dunf_clr(dunf_clr),
    .dunf_sticky(dunf_sticky1));

  ad_ip_jesd204_tpl_dac_datapath #(.NUM_LANES(2), .EXT_SYNC(0)) dut2 (
    .link_clk(clk), .link_resetn(link_resetn), .link_ready(link_ready),
    .link_valid(link_valid2), .link_data(link_data2), .enable(enable),
    .dac_valid(dac_valid2), .dac_ddata(dac_ddata[63:0]), .dac_dunf(dac_dunf),
    .dac_data_sel(dac_data_sel), .dac_pat_data(dac_pat_data), .dac_sync(dac_sync),
    .ext_sync(ext_sync), .sync_state(sync_state2), .dunf_clr(dunf_clr),
    .dunf_sticky(dunf_sticky2));

  function automatic logic [15:0] s4(input logic [127:0] d, input int c, input int j);
    return d[(c*4+j)*16 +: 16];
  endfunction

  function automatic logic [15:0] s2(input logic [63:0] d, input int c, input int j);
    return d[(c*2+j)*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    link_resetn = 1'b0; link_ready = 1'b1; enable = 2'b11; dac_data_sel = 8'h00;
    tick(); tick();
    total++; if (link_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", link_valid0); end
    total++; if (link_data0 !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", link_data0); end
    total++; if (dac_valid0 !== 2'b00) begin bad++; $display("FAIL reset_dac_valid got=%b exp=00", dac_valid0); end
    total++; if (dunf_sticky0 !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b exp=0", dunf_sticky0); end
    total++; if (sync_state0 !== 2'd2) begin bad++; $display("FAIL reset_state0 got=%0d exp=2", sync_state0); end
    total++; if (sync_state1 !== 2'd0) begin bad++; $display("FAIL reset_state1 got=%0d exp=0", sync_state1); end
  endtask

  task automatic test_ramp();
    dac_data_sel = 8'h22;
    link_resetn  = 1'b1;
    tick();
    total++; if (link_valid0 !== 1'b1) begin bad++; $display("FAIL ramp_valid got=%b exp=1", link_valid0); end
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (s4(link_data0, c, j) !== 16'(j)) begin bad++; $display("FAIL ramp_b0 c%0d j%0d got=%h exp=%h", c, j, s4(link_data0, c, j), 16'(j)); end
      end
    total++; if (s2(link_data2, 1, 1) !== 16'd1) begin bad++; $display("FAIL ramp2_b0 got=%h exp=1", s2(link_data2, 1, 1)); end
    tick();
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (s4(link_data0, c, j) !== 16'(4 + j)) begin bad++; $display("FAIL ramp_b1 c%0d j%0d got=%h exp=%h", c, j, s4(link_data0, c, j), 16'(4 + j)); end
      end
    total++; if (dac_valid0 !== 2'b00) begin bad++; $display("FAIL ramp_dac_valid got=%b exp=00", dac_valid0); end
  endtask

  task automatic test_ramp_wrap();
    int n = 0;
    while (n < 40000 && s2(link_data2, 0, 0) !== 16'hfffe) begin
      tick();
      n++;
    end
    total++; if (n != 32766) begin bad++; $display("FAIL wrap_beats got=%0d exp=32766", n); end
    total++; if (s2(link_data2, 0, 1) !== 16'hffff) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", s2(link_data2, 0, 1)); end
    tick();
    total++; if (s2(link_data2, 0, 0) !== 16'h0000) begin bad++; $display("FAIL wrap_0000 got=%h exp=0000", s2(link_data2, 0, 0)); end
    total++; if (s2(link_data2, 1, 1) !== 16'h0001) begin bad++; $display("FAIL wrap_0001 got=%h exp=0001", s2(link_data2, 1, 1)); end
  endtask

  task automatic test_dma_stall();
    logic [127:0] word_a = {4{32'hA1A2_A3A4}};
    logic [127:0] word_b = {4{32'hB1B2_B3B4}};
    logic [127:0] word_c = {4{32'hC1C2_C3C4}};
    dac_data_sel = 8'h00; enable = 2'b11; link_ready = 1'b1; dac_ddata = word_a;
    #1;
    total++; if (dac_valid0 !== 2'b11) begin bad++; $display("FAIL dma_valid got=%b exp=11", dac_valid0); end
    tick();
    total++; if (link_data0 !== word_a) begin bad++; $display("FAIL dma_a got=%h exp=%h", link_data0, word_a); end
    link_ready = 1'b0; dac_ddata = word_b;
    #1;
    total++; if (dac_valid0 !== 2'b00) begin bad++; $display("FAIL stall_valid got=%b exp=00", dac_valid0); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (link_data0 !== word_a) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", k, link_data0, word_a); end
    end
    link_ready = 1'b1; dac_ddata = word_c;
    #1;
    total++; if (dac_valid0 !== 2'b11) begin bad++; $display("FAIL resume_valid got=%b exp=11", dac_valid0); end
    tick();
    total++; if (link_data0 !== word_c) begin bad++; $display("FAIL resume_c got=%h exp=%h", link_data0, word_c); end
  endtask

  task automatic test_pattern();
    enable = 2'b01; dac_data_sel = 8'h11; dac_pat_data = {16'h5555, 16'h1234};
    tick();
    for (int j = 0; j < 4; j++) begin
      total++; if (s4(link_data0, 0, j) !== 16'h1234) begin bad++; $display("FAIL pat_ch0 j%0d got=%h exp=1234", j, s4(link_data0, 0, j)); end
      total++; if (s4(link_data0, 1, j) !== 16'h0000) begin bad++; $display("FAIL pat_ch1 j%0d got=%h exp=0000", j, s4(link_data0, 1, j)); end
    end
    total++; if (dac_valid0 !== 2'b00) begin bad++; $display("FAIL pat_dac_valid got=%b exp=00", dac_valid0); end
    enable = 2'b11; dac_data_sel = 8'h73;
    tick();
    total++; if (link_data0 !== '0) begin bad++; $display("FAIL zero_codes got=%h exp=0", link_data0); end
  endtask

  task automatic test_dunf();
    enable = 2'b11; dac_data_sel = 8'h11; dac_dunf = 1'b1; dunf_clr = 1'b0;
    tick();
    total++; if (dunf_sticky0 !== 1'b0) begin bad++; $display("FAIL dunf_no_dma got=%b exp=0", dunf_sticky0); end
    dac_data_sel = 8'h00; dac_dunf = 1'b1; dunf_clr = 1'b1;
    tick();
    total++; if (dunf_sticky0 !== 1'b1) begin bad++; $display("FAIL dunf_set_clr got=%b exp=1", dunf_sticky0); end
    dac_dunf = 1'b0;
    tick();
    total++; if (dunf_sticky0 !== 1'b0) begin bad++; $display("FAIL dunf_clr got=%b exp=0", dunf_sticky0); end
    dunf_clr = 1'b0;
  endtask

  task automatic test_midstream_reset();
    dac_data_sel = 8'h00; dac_ddata = {8{16'h7e7e}}; dac_dunf = 1'b1;
    tick();
    dac_dunf = 1'b0;
    total++; if (dunf_sticky0 !== 1'b1) begin bad++; $display("FAIL mid_pre_sticky got=%b exp=1", dunf_sticky0); end
    link_resetn = 1'b0;
    tick();
    total++; if (link_valid0 !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", link_valid0); end
    total++; if (link_data0 !== '0) begin bad++; $display("FAIL mid_data got=%h exp=0", link_data0); end
    total++; if (dac_valid0 !== 2'b00) begin bad++; $display("FAIL mid_dac_valid got=%b exp=00", dac_valid0); end
    total++; if (dunf_sticky0 !== 1'b0) begin bad++; $display("FAIL mid_sticky got=%b exp=0", dunf_sticky0); end
    link_resetn = 1'b1;
  endtask

  task automatic test_ext_sync();
    enable = 2'b11; dac_data_sel = 8'h22; link_ready = 1'b1;
    tick();
    total++; if (sync_state1 !== 2'd0) begin bad++; $display("FAIL sync_idle got=%0d exp=0", sync_state1); end
    dac_sync = 1'b1;
    tick();
    dac_sync = 1'b0;
    total++; if (sync_state1 !== 2'd1) begin bad++; $display("FAIL sync_armed got=%0d exp=1", sync_state1); end
    for (int k = 0; k < 9; k++) begin
      tick();
      total++; if (sync_state1 !== 2'd1 || link_data1 !== '0) begin bad++; $display("FAIL armed_hold%0d state=%0d data=%h exp state=1 data=0", k, sync_state1, link_data1); end
    end
    ext_sync = 1'b1;
    tick();
    ext_sync = 1'b0;
    total++; if (sync_state1 !== 2'd2) begin bad++; $display("FAIL sync_run got=%0d exp=2", sync_state1); end
    total++; if (link_data1 !== '0) begin bad++; $display("FAIL sync_entry_data got=%h exp=0", link_data1); end
    tick();
    for (int j = 0; j < 4; j++) begin
      total++; if (s4(link_data1, 1, j) !== 16'(j)) begin bad++; $display("FAIL sync_ramp j%0d got=%h exp=%h", j, s4(link_data1, 1, j), 16'(j)); end
    end
    tick();
    dac_sync = 1'b1;
    tick();
    dac_sync = 1'b0;
    total++; if (sync_state1 !== 2'd1) begin bad++; $display("FAIL rearm got=%0d exp=1", sync_state1); end
    dac_sync = 1'b1; ext_sync = 1'b1;
    tick();
    dac_sync = 1'b0; ext_sync = 1'b0;
    total++; if (sync_state1 !== 2'd2) begin bad++; $display("FAIL both_sync got=%0d exp=2", sync_state1); end
    tick();
    total++; if (s4(link_data1, 0, 0) !== 16'd0 || s4(link_data1, 0, 3) !== 16'd3) begin bad++; $display("FAIL ramp_restart got=%h,%h exp=0000,0003", s4(link_data1, 0, 0), s4(link_data1, 0, 3)); end
  endtask

  initial begin
    link_resetn = 1'b0; link_ready = 1'b1; enable = '0; dac_ddata = '0; dac_dunf = 1'b0;
    dac_data_sel = '0; dac_pat_data = '0; dac_sync = 1'b0; ext_sync = 1'b0; dunf_clr = 1'b0;
    test_reset();
    test_ramp();
    test_ramp_wrap();
    test_dma_stall();
    test_pattern();
    test_dunf();
    test_midstream_reset();
    test_ext_sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
